// File: rtl/cep_pkg_assembler_pkg.sv
// Shared CEP definitions for the package assembler: word geometry, header length field, FSM states.
package cep_pkg_assembler_pkg;

    localparam int CEP_WORD_WIDTH = 64;
    localparam int CEP_MAX_WORDS  = 8;
    localparam int CEP_DATA_WIDTH = CEP_WORD_WIDTH * CEP_MAX_WORDS;

    // Header length field: number of words following word 0.
    localparam int CEP_LEN_LSB = 56;
    localparam int CEP_LEN_W   = 4;

    typedef enum logic [1:0] {
        CEP_ASM_IDLE    = 2'd0,
        CEP_ASM_COLLECT = 2'd1,
        CEP_ASM_HOLD    = 2'd2
    } cep_asm_state_t;

    function automatic logic [CEP_LEN_W-1:0] cep_length(input logic [CEP_WORD_WIDTH-1:0] hdr);
        return hdr[CEP_LEN_LSB +: CEP_LEN_W];
    endfunction

endpackage

// File: rtl/cep_pkg_assembler.sv
// Assembles a header-prefixed stream of link words into one package vector
// and hands it downstream over a valid/ready handshake.
module cep_pkg_assembler
    import cep_pkg_assembler_pkg::*;
#(
    parameter int WORD_W    = CEP_WORD_WIDTH,
    parameter int MAX_WORDS = CEP_MAX_WORDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_val,
    input  logic [WORD_W-1:0]           in_data,
    output logic                        in_rdy,
    output logic                        pkg_val,
    output logic [MAX_WORDS*WORD_W-1:0] pkg_data,
    input  logic                        pkg_rdy,
    output logic                        len_err
);

    localparam int CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    cep_asm_state_t   state_reg;
    logic [CNT_W-1:0] idx_reg;
    logic [CNT_W-1:0] rem_reg;
    logic             pkg_val_reg;
    logic             len_err_reg;

    logic                 in_xfer;
    logic                 hdr_xfer;
    logic                 col_xfer;
    logic [CEP_LEN_W-1:0] hdr_len;
    logic                 len_too_long;
    logic [CNT_W-1:0]     len_clamp;
    logic [MAX_WORDS-1:0] word_we;

    // While holding a package, a new word may only enter as the old one leaves.
    assign in_rdy   = (state_reg != CEP_ASM_HOLD) || pkg_rdy;
    assign in_xfer  = in_val && in_rdy;
    assign hdr_xfer = in_xfer && (state_reg != CEP_ASM_COLLECT);
    assign col_xfer = in_xfer && (state_reg == CEP_ASM_COLLECT);

    assign hdr_len      = cep_length(CEP_WORD_WIDTH'(in_data));
    assign len_too_long = 32'(hdr_len) > 32'(MAX_WORDS - 1);
    assign len_clamp    = len_too_long ? CNT_W'(MAX_WORDS - 1) : CNT_W'(hdr_len);

    always_comb begin
        word_we = '0;
        if (hdr_xfer) begin
            word_we[0] = 1'b1;
        end else if (col_xfer) begin
            word_we[idx_reg] = 1'b1;
        end
    end

    // A header clears every slot so words past the length read as zero.
    generate
        for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_slot
            logic [WORD_W-1:0] slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (word_we[gi]) begin
                    slot_reg <= in_data;
                end else if (hdr_xfer) begin
                    slot_reg <= '0;
                end
            end

            assign pkg_data[gi*WORD_W +: WORD_W] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= CEP_ASM_IDLE;
            idx_reg     <= '0;
            rem_reg     <= '0;
            pkg_val_reg <= 1'b0;
            len_err_reg <= 1'b0;
        end else begin
            len_err_reg <= hdr_xfer && len_too_long;
            case (state_reg)
                CEP_ASM_IDLE, CEP_ASM_HOLD: begin
                    if (hdr_xfer) begin
                        rem_reg <= len_clamp;
                        idx_reg <= CNT_W'(1);
                        if (len_clamp == '0) begin
                            state_reg   <= CEP_ASM_HOLD;
                            pkg_val_reg <= 1'b1;
                        end else begin
                            state_reg   <= CEP_ASM_COLLECT;
                            pkg_val_reg <= 1'b0;
                        end
                    end else if (state_reg == CEP_ASM_HOLD && pkg_rdy) begin
                        state_reg   <= CEP_ASM_IDLE;
                        pkg_val_reg <= 1'b0;
                        idx_reg     <= '0;
                    end
                end
                CEP_ASM_COLLECT: begin
                    if (col_xfer) begin
                        if (rem_reg == CNT_W'(1)) begin
                            state_reg   <= CEP_ASM_HOLD;
                            pkg_val_reg <= 1'b1;
                            idx_reg     <= '0;
                            rem_reg     <= '0;
                        end else begin
                            idx_reg <= idx_reg + CNT_W'(1);
                            rem_reg <= rem_reg - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg   <= CEP_ASM_IDLE;
                    pkg_val_reg <= 1'b0;
                    idx_reg     <= '0;
                    rem_reg     <= '0;
                end
            endcase
        end
    end

    assign pkg_val = pkg_val_reg;
    assign len_err = len_err_reg;

endmodule

// File: tb/tb_cep_pkg_assembler.sv
// Directed and randomized checks of cep_pkg_assembler against a word-list
// reference model of the expected package.
module tb_cep_pkg_assembler;

    localparam int W    = 64;
    localparam int NW   = 8;
    localparam int DW   = W * NW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_val;
    logic [W-1:0]  in_data;
    logic          in_rdy;
    logic          pkg_val;
    logic [DW-1:0] pkg_data;
    logic          pkg_rdy;
    logic          len_err;

    int n_cmp = 0;
    int n_err = 0;
    int n_pkg = 0;

    always #5 clk = ~clk;

    cep_pkg_assembler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_val   (in_val),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .pkg_val  (pkg_val),
        .pkg_data (pkg_data),
        .pkg_rdy  (pkg_rdy),
        .len_err  (len_err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Offers one package (header + payload) and checks it while held downstream.
    task automatic run_pkg(input int len, input logic [W-1:0] hdr_base, input bit seq_words,
                           input int stall_at, input int stall_cycles, input int bp_cycles);
        logic [W-1:0]  w [NW];
        logic [DW-1:0] exp_pkg;
        logic [31:0]   len_v;
        int            n;
        len_v = 32'(len);
        n = (len > NW - 1) ? NW - 1 : len;
        w[0] = hdr_base;
        w[0][59:56] = len_v[3:0];
        for (int k = 1; k < NW; k++)
            w[k] = seq_words ? W'(k) : {$urandom, $urandom};
        exp_pkg = '0;
        for (int k = 0; k <= n; k++)
            exp_pkg[k*W +: W] = w[k];

        for (int k = 0; k <= n; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    in_val  = 1'b0;
                    in_data = {$urandom, $urandom};
                    pkg_rdy = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    chk("stall_pkg_val", DW'(pkg_val), DW'(0));
                end
            end
            in_val  = 1'b1;
            in_data = w[k];
            pkg_rdy = 1'b1;
            #1;
            chk("in_rdy_word", DW'(in_rdy), DW'(1));
            @(posedge clk); #1;
            chk("len_err", DW'(len_err), DW'((k == 0) && (len > NW - 1)));
            if (k < n)
                chk("pkg_val_early", DW'(pkg_val), DW'(0));
        end
        in_val = 1'b0;
        chk("pkg_val_done", DW'(pkg_val), DW'(1));
        chk("pkg_data", pkg_data, exp_pkg);
        n_pkg++;
        $display("pkg %0d: len=%0d words=%0d stall@%0d x%0d bp=%0d word0=%h", n_pkg, len, n + 1,
                 stall_at, stall_cycles, bp_cycles, w[0]);

        for (int b = 0; b < bp_cycles; b++) begin
            in_val  = 1'b1;
            in_data = {$urandom, $urandom};
            pkg_rdy = 1'b0;
            #1;
            chk("bp_in_rdy", DW'(in_rdy), DW'(0));
            @(posedge clk); #1;
            chk("bp_pkg_val", DW'(pkg_val), DW'(1));
            chk("bp_pkg_data", pkg_data, exp_pkg);
        end
        in_val = 1'b0;
    endtask

    task automatic drain();
        in_val  = 1'b0;
        pkg_rdy = 1'b1;
        @(posedge clk); #1;
        chk("drain_pkg_val", DW'(pkg_val), DW'(0));
        chk("drain_in_rdy", DW'(in_rdy), DW'(1));
    endtask

    initial begin
        rst_n   = 1'b0;
        in_val  = 1'b0;
        in_data = '0;
        pkg_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pkg_val", DW'(pkg_val), DW'(0));
        chk("rst_pkg_data", pkg_data, DW'(0));
        chk("rst_len_err", DW'(len_err), DW'(0));
        chk("rst_in_rdy", DW'(in_rdy), DW'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-word package.
        run_pkg(0, 64'hA5, 1'b0, 99, 0, 2);
        drain();

        // Full request with sequential payload.
        run_pkg(7, 64'h0, 1'b1, 99, 0, 1);
        drain();

        // Back-pressure, then next header accepted as pkg_rdy rises.
        run_pkg(3, {$urandom, $urandom}, 1'b0, 99, 0, 5);
        run_pkg(2, {$urandom, $urandom}, 1'b0, 99, 0, 0);

        // Back-to-back single-word packages.
        for (int i = 0; i < 4; i++)
            run_pkg(0, {$urandom, $urandom}, 1'b0, 99, 0, 0);

        // Stall mid-collect.
        run_pkg(4, {$urandom, $urandom}, 1'b0, 2, 3, 0);

        // Reset after word 2 of a 6-word package.
        in_val  = 1'b1;
        in_data = {$urandom, $urandom};
        in_data[59:56] = 4'd5;
        pkg_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_data = {$urandom, $urandom};
        end
        in_val = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_pkg_val", DW'(pkg_val), DW'(0));
        chk("arst_pkg_data", pkg_data, DW'(0));
        chk("arst_in_rdy", DW'(in_rdy), DW'(1));
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_pkg(0, {$urandom, $urandom}, 1'b0, 99, 0, 1);
        drain();

        // Over-long header lengths are clamped.
        run_pkg(12, {$urandom, $urandom}, 1'b0, 99, 0, 1);
        run_pkg(15, {$urandom, $urandom}, 1'b0, 3, 1, 0);
        drain();

        for (int i = 0; i < 12; i++)
            run_pkg(int'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b0,
                    int'($urandom_range(1, 8)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cep_pkg_assembler.md
Name: cep_pkg_assembler

Overview:
- Collects the CEP word stream arriving from the inter-chip link into one full `CEP_DATA_WIDTH` package vector.
- Presents that package to cep_decoder through a valid/ready handshake.
- Sits directly upstream of cep_decoder.
- Word 0 (header) carries `CEP_LENGTH`, the number of words that follow; package word k is stored at bits [(k+1)*W-1:k*W].

Parameters:
- WORD_W, `CEP_WORD_WIDTH, width of one link word.
- MAX_WORDS, 8, words per package; `CEP_DATA_WIDTH` = MAX_WORDS*WORD_W.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- in_val  input  1  link word valid
- in_data  input  WORD_W  link word
- in_rdy  output  1  assembler accepts in_data this cycle
- pkg_val  output  1  assembled package valid
- pkg_data  output  `CEP_DATA_WIDTH`  package, feeds cep_decoder.cep_pkg
- pkg_rdy  input  1  downstream consumes package
- len_err  output  1  one-cycle pulse: header length > MAX_WORDS-1

Behaviour:
- Clock/reset: one clock; rst_n asynchronous, active-low.
- Reset values: state=IDLE, pkg_val=0, pkg_data=0, word counter=0, remaining=0, len_err=0. in_rdy=1 after reset.
- Transfer rules: an input word transfers when in_val&&in_rdy; a package transfers when pkg_val&&pkg_rdy.
- IDLE:
  - Header transfer clears pkg_data to zero, writes word 0, and latches rem = header[`CEP_LENGTH`] (extracted from a zero-extended word-0 view).
  - rem==0 -> HOLD next cycle. rem>0 -> COLLECT, idx=1.
- COLLECT:
  - Each transfer writes word idx, then idx++ and rem--.
  - The transfer with rem==1 -> HOLD.
  - Words beyond the length stay zero.
- HOLD:
  - pkg_val=1; pkg_data stable until accepted.
  - in_rdy = pkg_rdy (pass-through).
  - pkg_rdy without an input transfer -> IDLE, pkg_val=0 next cycle.
  - pkg_rdy with a simultaneous header transfer: package handed off, new header processed exactly as in IDLE in the same cycle. Net effect: back-to-back, no bubble, pkg_val drops only if the new package needs more words.
- in_rdy = 1 in IDLE and COLLECT.
- Latency: last word accepted in cycle N -> pkg_val=1 in cycle N+1. Throughput: one word per cycle sustained.
- Length > MAX_WORDS-1 (only possible if the field is wider than 3 bits): clamp rem to MAX_WORDS-1 and pulse len_err for one cycle.
- Index arithmetic: idx is clog2(MAX_WORDS) bits. idx never exceeds MAX_WORDS-1, so there is no wrap.
- in_val low mid-COLLECT: stall with state held and no timeout.
- rst_n asserted mid-package: partial package discarded, outputs return to reset values asynchronously. The first word after reset release is a header.
- pkg_val is never withdrawn without pkg_rdy.

Decomposition:
- Shared package/defines (cep_defines.vh):
  - state encoding localparams CEP_ASM_IDLE / CEP_ASM_COLLECT / CEP_ASM_HOLD
  - CEP_MAX_WORDS = 8
- All field macros (`CEP_LENGTH` etc.) are reused unchanged.
- No sub-module; the word write-enable decoder is an always block inside.

Test Plan:
1. Single-word package: header with LENGTH=0, word 0 = 64'hA5 -> pkg_val next cycle, pkg_data[63:0]=64'hA5, bits above all zero.
2. Full request: header LENGTH=7, then words 1..7 = 64'h1..64'h7 with in_val held high, pkg_rdy=1 -> pkg_val exactly one cycle after the 8th word. Word k = k in each slot. cep_decoder data output = {7,6,5,4,3} for the request layout.
3. Back-pressure: pkg_rdy=0 for 5 cycles in HOLD with in_val=1 -> in_rdy=0, pkg_data unchanged. When pkg_rdy rises, the next header is accepted in the same cycle.
4. Back-to-back LENGTH=0 packages, pkg_rdy=1 -> in_rdy and pkg_val continuously 1. One package per cycle, each carrying the correct word 0.
5. Stall and reset: in_val dropped for 3 cycles mid-COLLECT -> no advance, correct package afterwards. Then rst_n asserted after word 2 of LENGTH=5 -> pkg_val=0 immediately, and the next accepted word is treated as a header.
6. Width stress (build with a 4-bit length field): header LENGTH=12 -> len_err pulses once, package completes after 7 further words.
